mem_stage_access: RTL
=====================

# mem_stage_access

Data-memory access controller for the MEM stage of the five-stage pipeline, sitting between the EX/MEM pipeline register and the MEM/WB pipeline register. It owns the byte-addressed data RAM and performs big-endian byte, halfword and word loads and stores with sign or zero extension. It models a configurable number of memory wait states and asserts `stall` to freeze the upstream stages until the access completes.

## Interface
Parameters:
- `ADDR_W`, 9: byte-address width; RAM depth is 2^ADDR_W bytes.
- `WAIT_CYCLES`, 2: extra cycles per access; 0 means a single-cycle access.

Ports:
- `clk` in 1: the single clock.
- `reset` in 1: synchronous, active-high.
- `mem_enable` in 1: access request from EX/MEM.
- `mem_rw` in 1: 1 = store, 0 = load.
- `mem_se` in 1: loads only; 1 = sign-extend, 0 = zero-extend.
- `mem_size` in 2: 00 = byte, 01 = halfword, 10 = word, 11 = reserved.
- `address` in ADDR_W: byte address; this is the ALU result.
- `data_in` in 32: store data; this is the forwarded PB value.
- `data_out` out 32: load result, passed to the MEM-stage result mux.
- `stall` out 1: 1 = hold the PC, IF/ID, ID/EX and EX/MEM registers.
- `done` out 1: one-cycle pulse in the completion cycle.
- `misaligned` out 1: one-cycle pulse in the completion cycle of a rejected access.

## Operation
- The RAM is a byte array `Mem[0:2^ADDR_W-1]`. The bench preloads it hierarchically. Reset never clears it.
- The FSM has two states, IDLE and WAIT.
  - IDLE with `mem_enable`=0: the block is idle.
  - IDLE with `mem_enable`=1 and WAIT_CYCLES=0: this cycle is the completion cycle and the state stays IDLE.
  - IDLE with `mem_enable`=1 and WAIT_CYCLES>0: latch `mem_rw`, `mem_se`, `mem_size`, `address` and `data_in`. Load the counter with WAIT_CYCLES-1 and go to WAIT.
  - WAIT with counter>0: decrement the counter.
  - WAIT with counter=0: this cycle is the completion cycle; return to IDLE at the edge.
- Inputs are ignored while in WAIT. The latched copy governs the access.
- Byte order is big-endian.
  - Word at A: `Mem[A]`=[31:24], `Mem[A+1]`=[23:16], `Mem[A+2]`=[15:8], `Mem[A+3]`=[7:0].
  - Halfword at A: `Mem[A]`=[15:8], `Mem[A+1]`=[7:0].
  - Byte at A: `Mem[A]`=[7:0].
- Stores write the low 8, 16 or 32 bits of the latched data at the clock edge that ends the completion cycle.
- Loads drive `data_out` combinationally from the array during the completion cycle. A byte or halfword is extended per `mem_se`.
- Outside the completion cycle, and for stores, `data_out`=0.
- An access is misaligned if it is a halfword with addr[0]≠0, a word with addr[1:0]≠0, or uses size 11. A misaligned access:
  - finishes on the same schedule as a normal access;
  - writes nothing to RAM;
  - returns `data_out`=0;
  - pulses `misaligned` together with `done`.
- Address arithmetic wraps modulo 2^ADDR_W. This only applies to aligned accesses, so it never triggers.

## Timing
- Reset values: state IDLE, counter 0, `stall`=0, `done`=0, `misaligned`=0, `data_out`=0.
- Cycle 0 is the first cycle `mem_enable` is seen in IDLE. The completion cycle is cycle WAIT_CYCLES.
- `stall`=1 in cycles 0..WAIT_CYCLES-1 and 0 in the completion cycle. The `stall` term from cycle 0 is combinational from `mem_enable`.
- With WAIT_CYCLES=0, `stall` is never asserted and back-to-back accesses complete one per cycle.
- The cycle after completion is in IDLE. If `mem_enable`=1 in that cycle, it starts a new access, because the pipeline has advanced.
- Reset asserted mid-access: the block returns to IDLE at that edge, no write commits, and `stall`, `done` and `misaligned` read 0 from the next cycle.
- A store to address A followed by a load from A returns the new data. The write commits before the load's completion cycle.

## Structure
- Shared package `mem_stage_pkg` holds:
  - the size encodings `SIZE_BYTE`, `SIZE_HALF`, `SIZE_WORD`;
  - the FSM state enum `IDLE` / `WAIT`.
- Sub-module `mem_lane_align` is combinational. It maps (size, se, addr low bits, bytes read) to the extended 32-bit result and produces the misaligned flag. The RAM, FSM and counter stay in the top module.

## Test plan
- Preload `Mem[0..3]`=80,01,02,03. Load word at addr 0 with WAIT_CYCLES=2 → `stall`=1 in cycles 0 and 1, then in cycle 2 `stall`=0, `done`=1 and `data_out`=32'h80010203.
- Load byte at addr 0: with `mem_se`=1 → `data_out`=32'hFFFFFF80; with `mem_se`=0 → 32'h00000080. Load halfword at addr 2 with `mem_se`=1 → 32'h00000203.
- Store halfword at addr 6 with `data_in`=32'hA5A5BEEF → after completion `Mem[6]`=BE and `Mem[7]`=EF, and `Mem[5]` and `Mem[8]` are unchanged. A following load word at addr 4 returns bytes 4..7 correctly.
- Store word at addr 2 → `misaligned` and `done` pulse in cycle 2, `Mem[0..7]` is unchanged, `data_out`=0.
- Store word at addr 8 with 32'h11223344, with `reset` asserted in cycle 1 → `Mem[8..11]` is unchanged and `stall`=0 from cycle 2.
- With WAIT_CYCLES=0, store word 32'hDEADBEEF at addr 12, then load word at addr 12 in the next cycle → `stall` is never 1 and the load returns 32'hDEADBEEF.

Source files
------------

// File: rtl/mem_stage_pkg.sv
// Shared encodings for the MEM-stage data-memory access controller.
package mem_stage_pkg;

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } state_t;

endpackage

// File: rtl/mem_stage_access_if.sv
// Request/response bundle between the EX/MEM register and the MEM-stage memory controller.
interface mem_stage_access_if #(
  parameter int ADDR_W = 9
);
  logic              mem_enable;
  logic              mem_rw;
  logic              mem_se;
  logic [1:0]        mem_size;
  logic [ADDR_W-1:0] address;
  logic [31:0]       data_in;
  logic [31:0]       data_out;
  logic              stall;
  logic              done;
  logic              misaligned;

  modport master (
    output mem_enable, mem_rw, mem_se, mem_size, address, data_in,
    input  data_out, stall, done, misaligned
  );

  modport slave (
    input  mem_enable, mem_rw, mem_se, mem_size, address, data_in,
    output data_out, stall, done, misaligned
  );
endinterface

// File: rtl/mem_lane_align.sv
// Big-endian lane selection and sign/zero extension of load data, plus alignment check.
module mem_lane_align
  import mem_stage_pkg::*;
(
  input  logic [1:0]  size,
  input  logic        se,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] rd_bytes,
  output logic [31:0] data,
  output logic        misaligned
);

  // rd_bytes holds Mem[A] in [31:24] down to Mem[A+3] in [7:0]
  always_comb begin
    data       = '0;
    misaligned = 1'b0;
    case (size)
      SIZE_BYTE: data = {{24{se & rd_bytes[31]}}, rd_bytes[31:24]};
      SIZE_HALF: begin
        misaligned = addr_lo[0];
        data       = {{16{se & rd_bytes[31]}}, rd_bytes[31:16]};
      end
      SIZE_WORD: begin
        misaligned = (addr_lo != 2'b00);
        data       = rd_bytes;
      end
      default: misaligned = 1'b1;
    endcase
  end

endmodule

// File: rtl/mem_stage_access.sv
// MEM-stage data-memory controller: byte RAM, wait-state FSM and pipeline stall generation.
module mem_stage_access
  import mem_stage_pkg::*;
#(
  parameter int ADDR_W      = 9,
  parameter int WAIT_CYCLES = 2
) (
  input logic               clk,
  input logic               reset,
  mem_stage_access_if.slave bus
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam int CNT_W = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;

  logic [7:0] mem [0:DEPTH-1];

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              rw_q, se_q;
  logic [1:0]        size_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wdata_q;

  logic              acc_rw, acc_se;
  logic [1:0]        acc_size;
  logic [ADDR_W-1:0] acc_addr, a1, a2, a3;
  logic [31:0]       acc_wdata, rd_bytes, load_data;
  logic              complete, stall_c, mis;

  // In WAIT the latched request governs; in IDLE the live request is the access
  assign acc_rw    = (state_q == IDLE) ? bus.mem_rw   : rw_q;
  assign acc_se    = (state_q == IDLE) ? bus.mem_se   : se_q;
  assign acc_size  = (state_q == IDLE) ? bus.mem_size : size_q;
  assign acc_addr  = (state_q == IDLE) ? bus.address  : addr_q;
  assign acc_wdata = (state_q == IDLE) ? bus.data_in  : wdata_q;

  assign a1 = acc_addr + ADDR_W'(1);
  assign a2 = acc_addr + ADDR_W'(2);
  assign a3 = acc_addr + ADDR_W'(3);
  assign rd_bytes = {mem[acc_addr], mem[a1], mem[a2], mem[a3]};

  mem_lane_align u_align (
    .size       (acc_size),
    .se         (acc_se),
    .addr_lo    (acc_addr[1:0]),
    .rd_bytes   (rd_bytes),
    .data       (load_data),
    .misaligned (mis)
  );

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    complete = 1'b0;
    stall_c  = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.mem_enable) begin
          if (WAIT_CYCLES == 0) begin
            complete = 1'b1;
          end else begin
            stall_c = 1'b1;
            state_d = WAIT;
            cnt_d   = CNT_W'(WAIT_CYCLES - 1);
          end
        end
      end
      WAIT: begin
        if (cnt_q != '0) begin
          stall_c = 1'b1;
          cnt_d   = cnt_q - CNT_W'(1);
        end else begin
          complete = 1'b1;
          state_d  = IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (state_q == IDLE && bus.mem_enable) begin
      rw_q    <= bus.mem_rw;
      se_q    <= bus.mem_se;
      size_q  <= bus.mem_size;
      addr_q  <= bus.address;
      wdata_q <= bus.data_in;
    end
  end

  // RAM contents survive reset; only an in-flight store is cancelled
  always_ff @(posedge clk) begin
    if (!reset && complete && acc_rw && !mis) begin
      case (acc_size)
        SIZE_BYTE: mem[acc_addr] <= acc_wdata[7:0];
        SIZE_HALF: begin
          mem[acc_addr] <= acc_wdata[15:8];
          mem[a1]       <= acc_wdata[7:0];
        end
        SIZE_WORD: begin
          mem[acc_addr] <= acc_wdata[31:24];
          mem[a1]       <= acc_wdata[23:16];
          mem[a2]       <= acc_wdata[15:8];
          mem[a3]       <= acc_wdata[7:0];
        end
        default: ;
      endcase
    end
  end

  assign bus.stall      = stall_c;
  assign bus.done       = complete;
  assign bus.misaligned = complete & mis;
  assign bus.data_out   = (complete && !acc_rw && !mis) ? load_data : 32'h0;

endmodule
